// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller: shift scoreboard of in-flight writers beside ID.
// Optional HZD_RF_BYPASS_EN: write-through register file, so the retiring writer needs no stall.
module pipe_hazard_scoreboard #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned LAT_W  = 2,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W = $clog2(STAGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_rs_used_i,
  input  logic             id_rt_used_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             id_regwrite_i,
  input  logic [LAT_W-1:0] id_lat_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic [SEL_W-1:0] fwd_a_o,
  output logic [SEL_W-1:0] fwd_b_o,
  output logic             sb_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [STAGES-1:0] vld_q;
  logic [RA_W-1:0]   rd_q  [STAGES];
  logic [LAT_W-1:0]  lat_q [STAGES];
  logic [SEL_W-1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_d;

  logic [1:0]        used_c;
  logic [RA_W-1:0]   addr_c [2];
  logic [1:0]        hz_c;
  logic [SEL_W-1:0]  sel_c  [2];
  logic              stall_c;
  logic              issue_c;

  assign used_c    = {id_rt_used_i, id_rs_used_i};
  assign addr_c[0] = id_rs_i;
  assign addr_c[1] = id_rt_i;

  // Scan oldest to youngest so the youngest matching writer decides.
  always_comb begin
    hz_c = '0;
    for (int s = 0; s < 2; s++) begin
      sel_c[s] = '0;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
        if (used_c[s] && (addr_c[s] != '0) && vld_q[i] && (rd_q[i] == addr_c[s])) begin
          if (i == int'(STAGES) - 1) begin
`ifdef HZD_RF_BYPASS_EN
            hz_c[s] = 1'b0;
`else
            hz_c[s] = 1'b1;
`endif
            sel_c[s] = '0;
          end else if ((i + 1) < int'(lat_q[i])) begin
            hz_c[s]  = 1'b1;
            sel_c[s] = '0;
          end else begin
            hz_c[s]  = 1'b0;
            sel_c[s] = SEL_W'(i + 2);
          end
        end
      end
    end
  end

  always_comb begin
    stall_c = id_valid_i & ~flush_i & (|hz_c);
    issue_c = id_valid_i & ~stall_c & ~flush_i;
    vld_d   = issue_c & id_regwrite_i & (id_rd_i != '0);
    fwd_a_d = issue_c ? sel_c[0] : '0;
    fwd_b_d = issue_c ? sel_c[1] : '0;
    cnt_d   = (stall_c && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Scoreboard always advances; a stall or flush inserts an empty entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        rd_q[i]  <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[STAGES-2:0], vld_d};
      rd_q[0]  <= id_rd_i;
      lat_q[0] <= id_lat_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        rd_q[i]  <= rd_q[i-1];
        lat_q[i] <= lat_q[i-1];
      end
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o       = stall_c;
  assign pc_write_o    = ~stall_c;
  assign ifid_write_o  = ~stall_c;
  assign idex_bubble_o = stall_c | flush_i;
  assign fwd_a_o       = fwd_a_q;
  assign fwd_b_o       = fwd_b_q;
  assign sb_busy_o     = |vld_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: per-register "last writer issue cycle" model plus directed scenarios.
module tb_pipe_hazard_scoreboard;
  localparam int STAGES = 3;
  localparam int RA_W = 5;
  localparam int LAT_W = 2;
  localparam int CNT_W = 16;
  localparam int SEL_W = $clog2(STAGES + 1);
`ifdef HZD_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, rs_used, rt_used, regwrite, flush;
  logic [RA_W-1:0] rs, rt, rd;
  logic [LAT_W-1:0] lat;
  logic stall, pc_write, ifid_write, bubble, busy;
  logic [SEL_W-1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int failures = 0;

  pipe_hazard_scoreboard #(.STAGES(STAGES), .RA_W(RA_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
    .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .id_rd_i(rd), .id_regwrite_i(regwrite),
    .id_lat_i(lat), .flush_i(flush), .stall_o(stall), .pc_write_o(pc_write),
    .ifid_write_o(ifid_write), .idex_bubble_o(bubble), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .sb_busy_o(busy), .stall_cnt_o(cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: youngest writer of each register is its most recent issue; age = cycles since issue.
  int cyc = 0;
  int last_t [32];
  int last_lat [32];
  int last_wr;
  int m_fwd_a, m_fwd_b, m_cnt;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      last_t[r] = -1000;
      last_lat[r] = 0;
    end
    last_wr = -1000;
    m_fwd_a = 0;
    m_fwd_b = 0;
    m_cnt = 0;
  endtask

  task automatic src(input bit used, input int a, output bit hz, output int sel);
    int age;
    hz = 1'b0;
    sel = 0;
    age = cyc - last_t[a];
    if (used && a != 0 && age >= 1 && age <= STAGES) begin
      if (age == STAGES) hz = !BYP;
      else if (age < last_lat[a]) hz = 1'b1;
      else sel = age + 1;
    end
  endtask

  initial begin
    bit hza, hzb, es, iss;
    int sa, sb;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      src(rs_used, int'(rs), hza, sa);
      src(rt_used, int'(rt), hzb, sb);
      es = id_valid && !flush && (hza || hzb);
      chk("stall", int'(stall), int'(es));
      chk("pc_write", int'(pc_write), int'(!es));
      chk("ifid_write", int'(ifid_write), int'(!es));
      chk("bubble", int'(bubble), int'(es || flush));
      chk("fwd_a", int'(fwd_a), m_fwd_a);
      chk("fwd_b", int'(fwd_b), m_fwd_b);
      chk("busy", int'(busy), int'((cyc - last_wr) <= STAGES));
      chk("stall_cnt", int'(cnt), m_cnt);
      if (!rst) begin
        iss = id_valid && !es && !flush;
        m_fwd_a = iss ? sa : 0;
        m_fwd_b = iss ? sb : 0;
        if (iss && regwrite && rd != 0) begin
          last_t[rd] = cyc;
          last_lat[rd] = int'(lat);
          last_wr = cyc;
        end
        if (es && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input int a, input bit au, input int b, input bit bu,
                     input int d, input bit w, input int l, input bit f);
    id_valid = v; rs = RA_W'(a); rs_used = au; rt = RA_W'(b); rt_used = bu;
    rd = RA_W'(d); regwrite = w; lat = LAT_W'(l); flush = f;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (n) step();
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 rst = 1'b1;
    repeat (2) step();
    chk("rst_stall", int'(stall), 0);
    chk("rst_pc_write", int'(pc_write), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt), 0);
    rst = 1'b0;
    step();

    // 1: ALU r1 then reader of r1
    drv(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    drv(1, 1, 1, 0, 0, 9, 1, 1, 0);
    @(negedge clk); chk("t1_stall", int'(stall), 0);
    step(); idle(0);
    @(negedge clk); chk("t1_fwd_a", int'(fwd_a), 2);
    idle(5);

    // 2: load r2 then reader of r2
    drv(1, 0, 0, 0, 0, 2, 1, 2, 0); step();
    drv(1, 2, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t2_stall1", int'(stall), 1);
    step();
    @(negedge clk); chk("t2_stall2", int'(stall), 0);
    step(); idle(0);
    @(negedge clk); chk("t2_fwd_a", int'(fwd_a), 3); chk("t2_cnt", int'(cnt), 1);
    idle(5);

    // 3: writer r3, two unrelated ops, reader of r3
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0); step();
    drv(1, 8, 1, 0, 0, 10, 1, 1, 0); step(); step();
    drv(1, 3, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t3_stall", int'(stall), BYP ? 0 : 1);
    step();
    if (!BYP) begin
      @(negedge clk); chk("t3_stall_retry", int'(stall), 0);
      step();
    end
    idle(0);
    @(negedge clk); chk("t3_fwd_a", int'(fwd_a), 0);
    idle(5);

    // 4: two writers of r4, reader on both operands
    drv(1, 0, 0, 0, 0, 4, 1, 1, 0); step(); step();
    drv(1, 4, 1, 4, 1, 0, 0, 1, 0);
    @(negedge clk); chk("t4_stall", int'(stall), 0);
    step(); idle(0);
    @(negedge clk); chk("t4_fwd_a", int'(fwd_a), 2); chk("t4_fwd_b", int'(fwd_b), 2);
    idle(5);

    // 5: load-use with flush in the same cycle
    drv(1, 0, 0, 0, 0, 5, 1, 2, 0); step();
    drv(1, 5, 1, 0, 0, 11, 1, 1, 1);
    @(negedge clk); chk("t5_stall", int'(stall), 0); chk("t5_bubble", int'(bubble), 1);
    step(); idle(0);
    @(negedge clk); chk("t5_fwd_a", int'(fwd_a), 0);
    idle(5);

    // 6: reset mid-stall, then r0 readers
    drv(1, 0, 0, 0, 0, 6, 1, 3, 0); step();
    drv(1, 6, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); chk("t6_stall_pre", int'(stall), 1);
    step();
    rst = 1'b1; #1;
    chk("t6_stall", int'(stall), 0); chk("t6_busy", int'(busy), 0);
    chk("t6_cnt", int'(cnt), 0); chk("t6_fwd_a", int'(fwd_a), 0);
    chk("t6_pc_write", int'(pc_write), 1);
    step(); rst = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 1, 2, 0); step();
    drv(1, 0, 1, 0, 1, 0, 0, 1, 0);
    @(negedge clk); chk("t6_r0_stall", int'(stall), 0);
    idle(5);

    // Random traffic on a small register set to force collisions
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(99) < 85, $urandom_range(7), $urandom_range(1), $urandom_range(7),
          $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(3, 1),
          $urandom_range(99) < 10);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
